// File: rtl/i2c_mst_arbiter_pkg.sv
// Shared types and widths for the i2c_mst_arbiter slice.
package i2c_arb_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/i2c_mst_arbiter_if.sv
// Requester and i2c_master command bundle for i2c_mst_arbiter.
// slave modport = arbiter view, master modport = requesters/i2c_master view.
interface i2c_mst_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned AW = i2c_arb_pkg::I2C_ADDR_W;
  localparam int unsigned DW = i2c_arb_pkg::I2C_DATA_W;

  logic [N_REQ-1:0]    req;
  logic [AW*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]    req_rw;
  logic [DW*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    done;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                mst_start;
  logic [AW-1:0]       mst_addr;
  logic                mst_rw;
  logic [DW-1:0]       mst_dfifo;
  logic                mst_busy;
  logic                mst_done;
  logic                mst_nack;
  logic [DW-1:0]       mst_rdata;
  logic                mst_abort;

  modport slave (
    input  req, req_addr, req_rw, req_wdata,
    input  mst_busy, mst_done, mst_nack, mst_rdata,
    output gnt, done, rsp_rdata, rsp_err,
    output mst_start, mst_addr, mst_rw, mst_dfifo, mst_abort
  );

  modport master (
    output req, req_addr, req_rw, req_wdata,
    output mst_busy, mst_done, mst_nack, mst_rdata,
    input  gnt, done, rsp_rdata, rsp_err,
    input  mst_start, mst_addr, mst_rw, mst_dfifo, mst_abort
  );

endinterface

// File: rtl/i2c_mst_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  int unsigned k;

  // scan N_REQ positions starting at rr_ptr; the first hit wins
  always_comb begin
    idx = '0;
    vld = 1'b0;
    k   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(rr_ptr) + i) % N_REQ;
      if (!vld && req[k]) begin
        vld = 1'b1;
        idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/i2c_mst_arbiter.sv
// Round-robin arbiter sharing one i2c_master between N_REQ requesters.
// Optional watchdog: define I2C_ARB_WDOG_EN to abort a transaction after TMO_CYC WAIT cycles.
module i2c_mst_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TMO_CYC = 20000
) (
  input logic               clk,
  input logic               rstn,
  i2c_mst_arbiter_if.slave  bus
);

  localparam int unsigned IW = $clog2(N_REQ);

  arb_state_t      state, state_nx;
  logic [IW-1:0]   rr_ptr, win, pick_idx;
  logic            pick_vld;
  logic [N_REQ-1:0] win_oh;
  logic            tmo, wd_abort;

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

`ifdef I2C_ARB_WDOG_EN
  logic [14:0] wd_cnt;

  // WAIT-cycle counter; held at zero outside WAIT so every entry starts from 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                  wd_cnt <= '0;
    else if (state == ST_WAIT)  wd_cnt <= wd_cnt + 1'b1;
    else                        wd_cnt <= '0;
  end

  assign tmo           = (state == ST_WAIT) && (wd_cnt == 15'(TMO_CYC - 1));
  assign bus.mst_abort = wd_abort;
`else
  // TMO_CYC has no effect without the watchdog
  logic [31:0] tmo_unused;
  assign tmo_unused    = TMO_CYC;
  assign tmo           = 1'b0;
  assign bus.mst_abort = 1'b0;
`endif

  // next-state logic; mst_done beats a same-cycle timeout
  always_comb begin
    state_nx = state;
    wd_abort = 1'b0;
    unique case (state)
      ST_IDLE:  if (pick_vld) state_nx = ST_GRANT;
      ST_GRANT: state_nx = ST_ISSUE;
      ST_ISSUE: if (!bus.mst_busy) state_nx = ST_WAIT;
      ST_WAIT: begin
        if (bus.mst_done) begin
          state_nx = ST_RESP;
        end else if (tmo) begin
          state_nx = ST_RESP;
          wd_abort = 1'b1;
        end
      end
      ST_RESP:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // grant and done are decoded from the held winner so reset drops them at once
  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
    bus.gnt     = (state != ST_IDLE) ? win_oh : '0;
    bus.done    = (state == ST_RESP) ? win_oh : '0;
  end

  // FSM, winner, rotation pointer, command latches and response registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      win           <= '0;
      rr_ptr        <= '0;
      bus.mst_start <= 1'b0;
      bus.mst_addr  <= '0;
      bus.mst_rw    <= 1'b0;
      bus.mst_dfifo <= '0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      // start is registered on the ISSUE->WAIT edge, so it is seen in the first WAIT cycle
      bus.mst_start <= (state == ST_ISSUE) && !bus.mst_busy;
      if (state == ST_IDLE && pick_vld) win <= pick_idx;
      if (state == ST_GRANT) begin
        bus.mst_addr  <= bus.req_addr[32'(win)*I2C_ADDR_W +: I2C_ADDR_W];
        bus.mst_rw    <= bus.req_rw[win];
        bus.mst_dfifo <= bus.req_wdata[32'(win)*I2C_DATA_W +: I2C_DATA_W];
      end
      if (state == ST_WAIT) begin
        if (bus.mst_done) begin
          bus.rsp_rdata <= bus.mst_rdata;
          bus.rsp_err   <= bus.mst_nack;
        end else if (wd_abort) begin
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b1;
        end
      end
      if (state == ST_RESP) rr_ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_mst_arbiter.sv
// Scoreboard bench for i2c_mst_arbiter: stimulus pushes expected responses,
// a monitor pops and compares whenever a done pulse appears.
module tb_i2c_mst_arbiter;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  i2c_mst_arbiter_if #(.N_REQ(4)) bus ();

  i2c_mst_arbiter #(.N_REQ(4), .TMO_CYC(100)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [3:0] done;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // response monitor
  initial begin
    logic [3:0] prev_done;
    exp_t e;
    prev_done = '0;
    forever begin
      @(negedge clk);
      if (rstn && (|bus.done)) begin
        chk("done_single_cycle", prev_done, 0);
        chk("gnt_matches_done", bus.gnt, bus.done);
        if (exp_q.size() == 0) begin
          chk("done_unexpected", bus.done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("done_vec", bus.done, e.done);
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", bus.rsp_err, e.err);
        end
      end
      prev_done = rstn ? bus.done : '0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  task automatic set_req(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd);
    bus.req_addr[i*7 +: 7]  = a;
    bus.req_rw[i]           = rw;
    bus.req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mst_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt == 4'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("gnt_release", ok, 1);
  endtask

  task automatic respond(input logic [7:0] rd, input logic nack);
    @(negedge clk);
    bus.mst_done  = 1'b1;
    bus.mst_rdata = rd;
    bus.mst_nack  = nack;
    @(negedge clk);
    bus.mst_done  = 1'b0;
    bus.mst_rdata = '0;
    bus.mst_nack  = 1'b0;
    wait_idle();
  endtask

  task automatic do_xact(input int w, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                         input logic [7:0] rd, input logic nack);
    bit ok;
    exp_t e;
    wait_start(ok);
    chk("mst_start_seen", ok, 1);
    chk("gnt_at_start", bus.gnt, 32'(1) << w);
    chk("mst_addr", bus.mst_addr, a);
    chk("mst_rw", bus.mst_rw, rw);
    chk("mst_dfifo", bus.mst_dfifo, wd);
    e.done  = 4'(1 << w);
    e.rdata = rd;
    e.err   = nack;
    exp_q.push_back(e);
    respond(rd, nack);
  endtask

  initial begin
    int nstart;
    bit ok;
    exp_t e;
    rstn          = 1'b0;
    bus.req       = '0;
    bus.req_addr  = '0;
    bus.req_rw    = '0;
    bus.req_wdata = '0;
    bus.mst_busy  = 1'b0;
    bus.mst_done  = 1'b0;
    bus.mst_nack  = 1'b0;
    bus.mst_rdata = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mst_start", bus.mst_start, 0);
    chk("rst_mst_addr", bus.mst_addr, 0);
    chk("rst_mst_dfifo", bus.mst_dfifo, 0);
    chk("rst_mst_abort", bus.mst_abort, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single write from requester 1, latency and early req drop
    set_req(1, 7'h50, 1'b0, 8'h5a);
    bus.req = 4'b0010;
    @(negedge clk);
    chk("t1_gnt", bus.gnt, 4'b0010);
    chk("t1_start_c1", bus.mst_start, 0);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t1_start_c2", bus.mst_start, 0);
    @(negedge clk);
    chk("t1_start_c3", bus.mst_start, 1);
    chk("t1_addr", bus.mst_addr, 7'h50);
    chk("t1_dfifo", bus.mst_dfifo, 8'h5a);
    chk("t1_rw", bus.mst_rw, 0);
    e.done = 4'b0010; e.rdata = 8'h00; e.err = 1'b0;
    exp_q.push_back(e);
    respond(8'h00, 1'b0);

    // stray mst_done in IDLE is ignored
    bus.mst_done = 1'b1; bus.mst_nack = 1'b1; bus.mst_rdata = 8'hff;
    @(negedge clk);
    bus.mst_done = 1'b0; bus.mst_nack = 1'b0; bus.mst_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("stray_gnt", bus.gnt, 0);
    chk("stray_err", bus.rsp_err, 0);
    chk("stray_rdata", bus.rsp_rdata, 0);

    // 2: read from requester 2 (rr_ptr = 2)
    set_req(2, 7'h3c, 1'b1, 8'h00);
    bus.req = 4'b0100;
    do_xact(2, 7'h3c, 1'b1, 8'h00, 8'ha5, 1'b0);
    bus.req = 4'b0000;

    // 5: master busy holds off start, then NACK (rr_ptr = 3)
    bus.mst_busy = 1'b1;
    set_req(3, 7'h21, 1'b0, 8'hc3);
    bus.req = 4'b1000;
    nstart = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.mst_start) nstart++;
    end
    chk("busy_no_start", nstart, 0);
    chk("busy_gnt", bus.gnt, 4'b1000);
    bus.mst_busy = 1'b0;
    do_xact(3, 7'h21, 1'b0, 8'hc3, 8'h00, 1'b1);
    bus.req = 4'b0000;

    // 3: contention, all four held (rr_ptr = 0)
    for (int i = 0; i < 4; i++) set_req(i, 7'(8'h10 + i), i[0], 8'(8'h80 + i));
    bus.req = 4'b1111;
    for (int w = 0; w < 4; w++) do_xact(w, 7'(8'h10 + w), w[0], 8'(8'h80 + w), 8'(8'h40 + w), 1'b0);
    bus.req = 4'b0000;

    // 4: wrap; move rr_ptr to 3 first
    set_req(2, 7'h12, 1'b0, 8'h11);
    bus.req = 4'b0100;
    do_xact(2, 7'h12, 1'b0, 8'h11, 8'h00, 1'b0);
    bus.req = 4'b0000;
    set_req(3, 7'h33, 1'b1, 8'h00);
    set_req(0, 7'h44, 1'b0, 8'h0f);
    bus.req = 4'b1001;
    do_xact(3, 7'h33, 1'b1, 8'h00, 8'h77, 1'b0);
    do_xact(0, 7'h44, 1'b0, 8'h0f, 8'h00, 1'b0);
    bus.req = 4'b0000;

    // reset mid-WAIT (rr_ptr = 1 before reset)
    set_req(2, 7'h66, 1'b1, 8'h99);
    bus.req = 4'b0100;
    wait_start(ok);
    chk("rst_mid_start", ok, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_gnt", bus.gnt, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_start_lo", bus.mst_start, 0);
    chk("rst_mid_addr", bus.mst_addr, 0);
    chk("rst_mid_rw", bus.mst_rw, 0);
    chk("rst_mid_rdata", bus.rsp_rdata, 0);
    bus.req = 4'b0000;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    set_req(3, 7'h55, 1'b0, 8'haa);
    set_req(0, 7'h0a, 1'b1, 8'h00);
    bus.req = 4'b1001;
    do_xact(0, 7'h0a, 1'b1, 8'h00, 8'h3e, 1'b0);
    do_xact(3, 7'h55, 1'b0, 8'haa, 8'h00, 1'b0);
    bus.req = 4'b0000;

`ifdef I2C_ARB_WDOG_EN
    // 6: watchdog, no mst_done (rr_ptr = 0 -> winner 1)
    set_req(1, 7'h2a, 1'b1, 8'h00);
    bus.req = 4'b0010;
    wait_start(ok);
    chk("wd_start", ok, 1);
    bus.req = 4'b0000;
    bus.mst_rdata = 8'hee;
    nstart = 0;
    for (int i = 1; i < 120; i++) begin
      @(negedge clk);
      if (bus.mst_abort) begin
        nstart = i;
        break;
      end
    end
    chk("wd_abort_cycle", nstart, 99);
    chk("wd_gnt_held", bus.gnt, 4'b0010);
    e.done = 4'b0010; e.rdata = 8'h00; e.err = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    chk("wd_abort_single", bus.mst_abort, 0);
    bus.mst_rdata = 8'h00;
    wait_idle();
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
